// File: rtl/timer_pkg.sv
// Shared types and default widths for the multi-channel countdown timer.
package timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  localparam int CNT_W_DEF = 32;
  localparam int PRE_W_DEF = 32;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: nested prescale/tick down-counters, latched config,
// one-cycle done pulse and sticky expired flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | stopped; waits for start with a non-zero period
//   ST_RUN  | counting pc (cycles in tick) and tc (ticks left) while enabled
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  input  logic             start,
  input  logic             abort,
  input  logic             periodic,
  input  logic [CNT_W-1:0] period,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  ch_state_e        state_q, state_d;
  logic [PRE_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic [PRE_W-1:0] peff_q, peff_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             exp_q, exp_d;

  logic [PRE_W-1:0] peff_in;
  logic             period_zero;
  logic             expiry;

  assign peff_in     = (prescale == '0) ? PRE_W'(1) : prescale;
  assign period_zero = (period == '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tc_d    = tc_q;
    peff_d  = peff_q;
    t_d     = t_q;
    mode_d  = mode_q;
    expiry  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !period_zero) begin
          state_d = ST_RUN;
          peff_d  = peff_in;
          t_d     = period;
          mode_d  = periodic;
          pc_d    = peff_in - PRE_W'(1);
          tc_d    = period;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          // A restart with period 0 stops the channel just like abort.
          if (period_zero) begin
            state_d = ST_IDLE;
          end else begin
            peff_d = peff_in;
            t_d    = period;
            mode_d = periodic;
            pc_d   = peff_in - PRE_W'(1);
            tc_d   = period;
          end
        end else if (enable) begin
          if (pc_q != '0) begin
            pc_d = pc_q - PRE_W'(1);
          end else if (tc_q != CNT_W'(1)) begin
            tc_d = tc_q - CNT_W'(1);
            pc_d = peff_q - PRE_W'(1);
          end else begin
            expiry = 1'b1;
            if (mode_q) begin
              pc_d = peff_q - PRE_W'(1);
              tc_d = t_q;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = expiry;
    exp_d  = (exp_q & ~clear) | expiry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      tc_q    <= '0;
      peff_q  <= '0;
      t_q     <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tc_q    <= tc_d;
      peff_q  <= peff_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      exp_q   <= exp_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;
  assign expired = exp_q;

endmodule

// File: rtl/multi_channel_timer.sv
// NUM_CH independent countdown channels sharing one prescale input;
// irq is the OR of all sticky expired flags.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PRE_W  = PRE_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PRE_W-1:0]        prescale,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH-1:0]       clear,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       expired,
  output logic                    irq
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W),
      .PRE_W(PRE_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .prescale(prescale),
      .start   (start[i]),
      .abort   (abort[i]),
      .periodic(periodic[i]),
      .period  (period[i*CNT_W +: CNT_W]),
      .clear   (clear[i]),
      .busy    (busy[i]),
      .done    (done[i]),
      .expired (expired[i])
    );
  end

  assign irq = |expired;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: a cycles-remaining model per channel
// is compared every cycle, plus literal done-edge expectations per scenario.
module tb_multi_channel_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int PRE_W  = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    enable = 1'b1;
  logic [PRE_W-1:0]        prescale = '0;
  logic [NUM_CH-1:0]       start = '0;
  logic [NUM_CH-1:0]       abort = '0;
  logic [NUM_CH-1:0]       periodic = '0;
  logic [NUM_CH*CNT_W-1:0] period = '0;
  logic [NUM_CH-1:0]       clear = '0;
  logic [NUM_CH-1:0]       busy, done, expired;
  logic                    irq;

  multi_channel_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .prescale(prescale),
    .start(start), .abort(abort), .periodic(periodic), .period(period),
    .clear(clear), .busy(busy), .done(done), .expired(expired), .irq(irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy0_total = 0;
  int dlog_ch[$];
  int dlog_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each running channel holds the number of enabled edges left
  // until its next expiry (P_eff*T on every load).
  logic [NUM_CH-1:0] m_act, m_done, m_exp, m_per, m_fire;
  longint unsigned   rem [NUM_CH];
  longint unsigned   rld [NUM_CH];

  function automatic longint unsigned load_val(input int ch);
    longint unsigned pe, t;
    pe = (prescale == 0) ? 64'd1 : 64'(prescale);
    t  = 64'(period[ch*CNT_W +: CNT_W]);
    return pe * t;
  endfunction

  always_comb begin
    m_fire = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      m_fire[ch] = m_act[ch] && !abort[ch] && !start[ch] && enable && (rem[ch] == 1);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act  <= '0;
      m_done <= '0;
      m_exp  <= '0;
      m_per  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        rem[ch] <= 0;
        rld[ch] <= 0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (m_act[ch] && abort[ch]) begin
          m_act[ch] <= 1'b0;
        end else if (start[ch]) begin
          m_act[ch] <= (load_val(ch) != 0);
          rem[ch]   <= load_val(ch);
          rld[ch]   <= load_val(ch);
          m_per[ch] <= periodic[ch];
        end else if (m_act[ch] && enable) begin
          if (rem[ch] == 1) begin
            if (m_per[ch]) rem[ch] <= rld[ch];
            else m_act[ch] <= 1'b0;
          end else begin
            rem[ch] <= rem[ch] - 1;
          end
        end
        m_done[ch] <= m_fire[ch];
        m_exp[ch]  <= (m_exp[ch] & ~clear[ch]) | m_fire[ch];
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_act);
    chk("done", done, m_done);
    chk("expired", expired, m_exp);
    chk("irq", irq, |m_exp);
    for (int ch = 0; ch < NUM_CH; ch++)
      if (done[ch] === 1'b1) begin
        dlog_ch.push_back(ch);
        dlog_cyc.push_back(cyc);
      end
    if (busy[0] === 1'b1) busy0_total <= busy0_total + 1;
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic dclr();
    dlog_ch.delete();
    dlog_cyc.delete();
  endtask

  function automatic int dget(input int i);
    return (i < dlog_cyc.size()) ? dlog_cyc[i] : -1;
  endfunction

  function automatic int dgetch(input int i);
    return (i < dlog_ch.size()) ? dlog_ch[i] : -1;
  endfunction

  task automatic set_per(input int ch, input logic [CNT_W-1:0] v);
    period[ch*CNT_W +: CNT_W] = v;
  endtask

  task automatic do_start(input int ch, output int e0);
    nxt();
    start[ch] = 1'b1;
    e0 = cyc + 1;
    nxt();
    start[ch] = 1'b0;
  endtask

  task automatic pulse_clear(input logic [NUM_CH-1:0] m);
    clear = m;
    nxt();
    clear = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int e0, b0, er;

    // reset
    nxt();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_expired", expired, 0);
    chk("rst_irq", irq, 0);
    nxt();
    rst = 1'b0;
    nxt();

    // single-shot, P=255 T=1
    prescale = 255;
    set_per(0, 1);
    dclr();
    b0 = busy0_total;
    do_start(0, e0);
    repeat (260) nxt();
    chk("t1_ndone", dlog_cyc.size(), 1);
    chk("t1_done_cyc", dget(0), e0 + 255);
    chk("t1_busy_cycles", busy0_total - b0, 255);
    chk("t1_expired", expired[0], 1);
    chk("t1_irq", irq, 1);
    pulse_clear(4'b0001);
    chk("t1_clr_expired", expired[0], 0);
    chk("t1_clr_irq", irq, 0);

    // periodic ch1, P=4 T=3, abort at E0+40
    prescale = 4;
    set_per(1, 3);
    periodic[1] = 1'b1;
    dclr();
    do_start(1, e0);
    repeat (39) nxt();
    abort[1] = 1'b1;
    nxt();
    abort[1] = 1'b0;
    chk("t2_busy_after_abort", busy[1], 0);
    repeat (20) nxt();
    chk("t2_ndone", dlog_cyc.size(), 3);
    chk("t2_d0", dget(0), e0 + 12);
    chk("t2_d1", dget(1), e0 + 24);
    chk("t2_d2", dget(2), e0 + 36);
    chk("t2_ch", (dgetch(0) == 1 && dgetch(1) == 1 && dgetch(2) == 1), 1);
    periodic[1] = 1'b0;
    pulse_clear(4'b0010);

    // enable freeze: P=10 T=2, 10 frozen edges
    prescale = 10;
    set_per(2, 2);
    dclr();
    do_start(2, e0);
    repeat (4) nxt();
    enable = 1'b0;
    repeat (10) nxt();
    enable = 1'b1;
    repeat (20) nxt();
    chk("t3_ndone", dlog_cyc.size(), 1);
    chk("t3_done_cyc", dget(0), e0 + 30);
    pulse_clear(4'b0100);

    // prescale 0 behaves as 1
    prescale = 0;
    set_per(3, 5);
    dclr();
    do_start(3, e0);
    repeat (10) nxt();
    chk("t4_ndone", dlog_cyc.size(), 1);
    chk("t4_done_cyc", dget(0), e0 + 5);
    pulse_clear(4'b1000);

    // period 0 start is ignored
    set_per(0, 0);
    dclr();
    do_start(0, e0);
    chk("t5_busy", busy[0], 0);
    repeat (20) nxt();
    chk("t5_ndone", dlog_cyc.size(), 0);
    chk("t5_expired", expired[0], 0);

    // maximal period: no early expiry
    prescale = 1;
    set_per(0, 32'hFFFF_FFFF);
    dclr();
    do_start(0, e0);
    repeat (1000) nxt();
    chk("t6_ndone", dlog_cyc.size(), 0);
    chk("t6_busy", busy[0], 1);
    abort[0] = 1'b1;
    nxt();
    abort[0] = 1'b0;
    chk("t6_busy_abort", busy[0], 0);

    // start+abort together in RUN -> idle
    prescale = 4;
    set_per(1, 3);
    dclr();
    do_start(1, e0);
    repeat (3) nxt();
    start[1] = 1'b1;
    abort[1] = 1'b1;
    nxt();
    start[1] = 1'b0;
    abort[1] = 1'b0;
    chk("t7_busy", busy[1], 0);
    repeat (20) nxt();
    chk("t7_ndone", dlog_cyc.size(), 0);

    // restart at E0+7 -> done at E0+19
    dclr();
    do_start(1, e0);
    repeat (6) nxt();
    start[1] = 1'b1;
    er = cyc + 1;
    nxt();
    start[1] = 1'b0;
    repeat (20) nxt();
    chk("t8_restart_edge", er, e0 + 7);
    chk("t8_ndone", dlog_cyc.size(), 1);
    chk("t8_done_cyc", dget(0), e0 + 19);
    pulse_clear(4'b0010);

    // clear in the expiry cycle: set wins
    prescale = 2;
    set_per(2, 2);
    dclr();
    do_start(2, e0);
    repeat (3) nxt();
    clear[2] = 1'b1;
    nxt();
    clear[2] = 1'b0;
    chk("t9_done_now", done[2], 1);
    chk("t9_expired_kept", expired[2], 1);
    nxt();
    pulse_clear(4'b0100);
    chk("t9_expired_cleared", expired[2], 0);

    // async reset while all four channels run periodically
    prescale = 4;
    for (int ch = 0; ch < NUM_CH; ch++) set_per(ch, 3);
    periodic = '1;
    nxt();
    start = '1;
    nxt();
    start = '0;
    repeat (14) nxt();
    chk("t10_pre_busy", busy, 4'hF);
    chk("t10_pre_expired", expired, 4'hF);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t10_rst_busy", busy, 0);
    chk("t10_rst_done", done, 0);
    chk("t10_rst_expired", expired, 0);
    chk("t10_rst_irq", irq, 0);
    repeat (2) nxt();
    rst = 1'b0;
    periodic = '0;
    dclr();
    repeat (30) nxt();
    chk("t10_ndone_after", dlog_cyc.size(), 0);
    chk("t10_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
